// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader (state encoding, word geometry, halt value).
package instruction_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [DATA_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction loader.
interface instruction_loader_if;
    import instruction_loader_pkg::*;

    logic [BYTE_W-1:0] i_rx_data;
    logic              i_rx_valid;
    logic              o_write_instruction_flag;
    logic [DATA_W-1:0] o_instruction_to_write;
    logic [DATA_W-1:0] o_address_to_write_inst;

    modport master (
        input  i_rx_data,
        input  i_rx_valid,
        output o_write_instruction_flag,
        output o_instruction_to_write,
        output o_address_to_write_inst
    );

    modport slave (
        output i_rx_data,
        output i_rx_valid,
        input  o_write_instruction_flag,
        input  o_instruction_to_write,
        input  o_address_to_write_inst
    );

endinterface

// File: rtl/instruction_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_ready pulses the cycle after byte 3.
module instruction_loader_byte_packer
    import instruction_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_ready,
    output logic [1:0]        o_byte_index
);

    // Bytes 0..2 wait here; byte 3 completes the word straight into o_word so the
    // next word's byte 0 can land during the write pulse without disturbing it.
    logic [3*BYTE_W-1:0] partial_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            partial_q    <= '0;
            o_byte_index <= '0;
            o_word       <= '0;
            o_word_ready <= 1'b0;
        end else if (i_clear) begin
            partial_q    <= '0;
            o_byte_index <= '0;
            o_word_ready <= 1'b0;
        end else begin
            o_word_ready <= 1'b0;
            if (i_accept) begin
                o_byte_index <= o_byte_index + 2'd1;
                case (o_byte_index)
                    2'd0: partial_q[BYTE_W-1:0]          <= i_byte;
                    2'd1: partial_q[2*BYTE_W-1:BYTE_W]   <= i_byte;
                    2'd2: partial_q[3*BYTE_W-1:2*BYTE_W] <= i_byte;
                    default: begin
                        o_word       <= {i_byte, partial_q};
                        o_word_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Loads a program from a byte stream into instruction memory, one aligned word write per 4 bytes.
// Optional inter-byte timeout enabled by defining INSTR_LOADER_TIMEOUT_EN.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned       ADDR_WIDTH     = 8,
    parameter int unsigned       MEM_BYTES      = 256,
    parameter logic [DATA_W-1:0] HALT_WORD      = HALT_WORD_DEFAULT,
    parameter int unsigned       TIMEOUT_CYCLES = 100000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    instruction_loader_if.master    bus,
    output logic                    o_loading,
    output logic                    o_done,
    output logic                    o_error,
    output logic [ADDR_WIDTH-2:0]   o_word_count
);

    localparam int unsigned CNT_W     = ADDR_WIDTH - 1;
    localparam int unsigned LAST_ADDR = MEM_BYTES - WORD_BYTES;

    state_t                 state_q, state_d;
    logic                   loading_d, done_d, error_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   accept_c, last_word_c, timeout_c;
    logic                   word_ready;
    logic [1:0]             byte_index;
    logic [DATA_W-1:0]      word;

    // i_start wins over a same-cycle byte and wipes any partial or pending word.
    assign accept_c    = (state_q == ST_COLLECT) && bus.i_rx_valid && !i_start;
    assign last_word_c = (addr_q == ADDR_WIDTH'(LAST_ADDR));

    instruction_loader_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (i_start),
        .i_accept     (accept_c),
        .i_byte       (bus.i_rx_data),
        .o_word       (word),
        .o_word_ready (word_ready),
        .o_byte_index (byte_index)
    );

    assign bus.o_write_instruction_flag = word_ready;
    assign bus.o_instruction_to_write   = word;
    assign bus.o_address_to_write_inst  = DATA_W'(addr_q);

`ifdef INSTR_LOADER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;

    // Counts idle cycles while a word is partially assembled; a byte this cycle beats expiry.
    assign timeout_c = (state_q == ST_COLLECT) && (byte_index != 2'd0) && !accept_c &&
                       !i_start && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tmo_q <= '0;
        end else if (i_start || accept_c || (state_q != ST_COLLECT) || (byte_index == 2'd0)) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    logic [33:0] unused_tmo;
    assign unused_tmo = {32'(TIMEOUT_CYCLES), byte_index};
    assign timeout_c  = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            o_loading <= 1'b0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
        end else begin
            state_q   <= state_d;
            o_loading <= loading_d;
            o_done    <= done_d;
            o_error   <= error_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: begin
                if (i_start) begin
                    state_d = ST_COLLECT;
                end else if (word_ready) begin
                    if (word == HALT_WORD) begin
                        state_d = ST_DONE;
                    end else if (last_word_c) begin
                        state_d = ST_ERROR;
                    end
                end else if (timeout_c) begin
                    state_d = ST_ERROR;
                end
            end
            default: begin
                if (i_start) begin
                    state_d = ST_COLLECT;
                end
            end
        endcase
    end

    // Output decode of the next state, registered above.
    always_comb begin
        loading_d = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        case (state_d)
            ST_COLLECT: loading_d = 1'b1;
            ST_DONE:    done_d    = 1'b1;
            ST_ERROR:   error_d   = 1'b1;
            default:    ;
        endcase
    end

    // Address holds at the last slot rather than wrapping past the end of memory.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            addr_q       <= '0;
            o_word_count <= '0;
        end else if (i_start) begin
            addr_q       <= '0;
            o_word_count <= '0;
        end else if (word_ready) begin
            o_word_count <= o_word_count + CNT_W'(1);
            if (!last_word_c) begin
                addr_q <= addr_q + ADDR_WIDTH'(WORD_BYTES);
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized self-checking bench for instruction_loader against a word-level reference model.
module tb_instruction_loader;
    import instruction_loader_pkg::*;

    localparam int unsigned MEM   = 16;
    localparam int unsigned TMO   = 10;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_start = 1'b0;
    logic       o_loading, o_done, o_error;
    logic [6:0] o_word_count;

    instruction_loader_if ifc ();

    instruction_loader #(
        .ADDR_WIDTH(8), .MEM_BYTES(MEM), .HALT_WORD(HALTW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .bus(ifc),
        .o_loading(o_loading), .o_done(o_done), .o_error(o_error), .o_word_count(o_word_count)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  stim[$];
    int          byte_cyc[$];
    logic [31:0] act_data[$], act_addr[$];
    int          act_cyc[$];
    logic [31:0] exp_data[$], exp_addr[$];
    int          exp_cyc[$];
    bit          exp_done, exp_err;
    int          term_cyc;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Record every write pulse and the first cycle a terminal flag is seen.
    always @(negedge i_clk) begin
        if (i_reset) begin
            if (ifc.o_write_instruction_flag) begin
                act_data.push_back(ifc.o_instruction_to_write);
                act_addr.push_back(ifc.o_address_to_write_inst);
                act_cyc.push_back(cyc);
            end
            if ((o_done || o_error) && term_cyc < 0) term_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) stim.push_back(w[8*k +: 8]);
    endtask

    // Start a load, then feed stim[] with random or zero gaps.
    task automatic run_stream(input bit b2b);
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        act_data = {}; act_addr = {}; act_cyc = {}; byte_cyc = {};
        term_cyc = -1;
        foreach (stim[i]) begin
            ifc.i_rx_valid = 1'b1;
            ifc.i_rx_data  = stim[i];
            byte_cyc.push_back(cyc);
            tick();
            ifc.i_rx_valid = 1'b0;
            if (!b2b) repeat ($urandom_range(0, 2)) tick();
        end
        repeat (4) tick();
    endtask

    // Reference: every 4 bytes form one LE word at address 4*i, written the cycle after its
    // last byte; the load stops after a halt word or after the word in the last memory slot.
    task automatic model();
        logic [31:0] w;
        exp_data = {}; exp_addr = {}; exp_cyc = {};
        exp_done = 1'b0; exp_err = 1'b0;
        for (int i = 0; i < stim.size() / 4; i++) begin
            w = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
            exp_data.push_back(w);
            exp_addr.push_back(32'(4 * i));
            exp_cyc.push_back(byte_cyc[4*i+3] + 1);
            if (w == HALTW) begin exp_done = 1'b1; break; end
            if (4 * i == int'(MEM) - 4) begin exp_err = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        ifc.i_rx_valid = 1'b0;
        ifc.i_rx_data  = '0;
        i_reset = 1'b0;
        repeat (2) tick();
        checks++; if ({ifc.o_write_instruction_flag, o_loading, o_done, o_error} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000",
                {ifc.o_write_instruction_flag, o_loading, o_done, o_error}); end
        checks++; if (ifc.o_instruction_to_write !== 32'h0 || ifc.o_address_to_write_inst !== 32'h0) begin
            errors++; $display("FAIL reset_bus got data %h addr %h want 0 0",
                ifc.o_instruction_to_write, ifc.o_address_to_write_inst); end
        checks++; if (o_word_count !== 7'd0) begin
            errors++; $display("FAIL reset_count got %0d want 0", o_word_count); end
        i_reset = 1'b1;
        // Bytes in IDLE must be ignored.
        for (int i = 0; i < 4; i++) begin
            ifc.i_rx_valid = 1'b1; ifc.i_rx_data = 8'($urandom); tick();
        end
        ifc.i_rx_valid = 1'b0;
        repeat (2) tick();
        checks++; if (o_word_count !== 7'd0 || o_loading !== 1'b0) begin
            errors++; $display("FAIL idle_ignore got count %0d loading %b want 0 0", o_word_count, o_loading); end
    endtask

    task automatic test_single_word();
        stim = {8'h13, 8'h00, 8'h10, 8'h00};
        run_stream(1'b0);
        checks++; if (act_data.size() != 1) begin
            errors++; $display("FAIL single_nwrites got %0d want 1", act_data.size()); end
        else begin
            checks++; if (act_data[0] !== 32'h0010_0013 || act_addr[0] !== 32'h0) begin
                errors++; $display("FAIL single_write got %h@%h want 00100013@0", act_data[0], act_addr[0]); end
            checks++; if (act_cyc[0] != byte_cyc[3] + 1) begin
                errors++; $display("FAIL single_latency got cyc %0d want %0d", act_cyc[0], byte_cyc[3] + 1); end
        end
        checks++; if (o_word_count !== 7'd1 || o_loading !== 1'b1 || o_done !== 1'b0 || o_error !== 1'b0) begin
            errors++; $display("FAIL single_state got cnt %0d ld %b dn %b er %b want 1 1 0 0",
                o_word_count, o_loading, o_done, o_error); end
    endtask

    task automatic test_halt();
        stim = {};
        push_word(32'h2008_0005);
        push_word(HALTW);
        push_word(32'h1234_5678);
        run_stream(1'b0);
        model();
        checks++; if (act_data.size() != exp_data.size()) begin
            errors++; $display("FAIL halt_nwrites got %0d want %0d", act_data.size(), exp_data.size()); end
        else foreach (exp_data[i]) begin
            checks++; if (act_data[i] !== exp_data[i] || act_addr[i] !== exp_addr[i] || act_cyc[i] != exp_cyc[i]) begin
                errors++; $display("FAIL halt_write%0d got %h@%h c%0d want %h@%h c%0d", i,
                    act_data[i], act_addr[i], act_cyc[i], exp_data[i], exp_addr[i], exp_cyc[i]); end
        end
        checks++; if (o_done !== exp_done || o_error !== exp_err || o_loading !== 1'b0 || o_word_count !== 7'(exp_data.size())) begin
            errors++; $display("FAIL halt_state got dn %b er %b ld %b cnt %0d want %b %b 0 %0d",
                o_done, o_error, o_loading, o_word_count, exp_done, exp_err, exp_data.size()); end
        checks++; if (term_cyc != exp_cyc[exp_cyc.size()-1] + 1) begin
            errors++; $display("FAIL halt_done_time got %0d want %0d", term_cyc, exp_cyc[exp_cyc.size()-1] + 1); end
    endtask

    task automatic test_back_to_back();
        stim = {};
        push_word($urandom & 32'h7FFF_FFFF);
        push_word($urandom & 32'h7FFF_FFFF);
        run_stream(1'b1);
        model();
        checks++; if (act_data.size() != 2) begin
            errors++; $display("FAIL b2b_nwrites got %0d want 2", act_data.size()); end
        else foreach (exp_data[i]) begin
            checks++; if (act_data[i] !== exp_data[i] || act_addr[i] !== exp_addr[i] || act_cyc[i] != exp_cyc[i]) begin
                errors++; $display("FAIL b2b_write%0d got %h@%h c%0d want %h@%h c%0d", i,
                    act_data[i], act_addr[i], act_cyc[i], exp_data[i], exp_addr[i], exp_cyc[i]); end
        end
        checks++; if (o_word_count !== 7'd2 || o_loading !== 1'b1) begin
            errors++; $display("FAIL b2b_state got cnt %0d ld %b want 2 1", o_word_count, o_loading); end
    endtask

    task automatic test_overflow();
        stim = {};
        for (int i = 0; i < 5; i++) push_word($urandom & 32'hFFFF_FFFE);
        run_stream(1'b0);
        model();
        checks++; if (act_data.size() != 4) begin
            errors++; $display("FAIL ovf_nwrites got %0d want 4", act_data.size()); end
        else foreach (exp_data[i]) begin
            checks++; if (act_data[i] !== exp_data[i] || act_addr[i] !== exp_addr[i] || act_cyc[i] != exp_cyc[i]) begin
                errors++; $display("FAIL ovf_write%0d got %h@%h c%0d want %h@%h c%0d", i,
                    act_data[i], act_addr[i], act_cyc[i], exp_data[i], exp_addr[i], exp_cyc[i]); end
        end
        checks++; if (o_error !== 1'b1 || o_done !== 1'b0 || o_loading !== 1'b0 || o_word_count !== 7'd4) begin
            errors++; $display("FAIL ovf_state got er %b dn %b ld %b cnt %0d want 1 0 0 4",
                o_error, o_done, o_loading, o_word_count); end
        checks++; if (term_cyc != exp_cyc[exp_cyc.size()-1] + 1) begin
            errors++; $display("FAIL ovf_err_time got %0d want %0d", term_cyc, exp_cyc[exp_cyc.size()-1] + 1); end
    endtask

    task automatic test_restart();
        logic [31:0] w;
        int last_c;
        w = $urandom & 32'h7FFF_FFFF;
        tick();
        i_start = 1'b1; tick(); i_start = 1'b0;
        act_data = {}; act_addr = {}; act_cyc = {};
        for (int i = 0; i < 2; i++) begin
            ifc.i_rx_valid = 1'b1; ifc.i_rx_data = 8'($urandom); tick();
        end
        // Restart with a coincident byte: that byte must be dropped.
        i_start = 1'b1; ifc.i_rx_data = 8'hAA; tick(); i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ifc.i_rx_data = w[8*k +: 8]; last_c = cyc; tick();
        end
        ifc.i_rx_valid = 1'b0;
        repeat (3) tick();
        checks++; if (act_data.size() != 1) begin
            errors++; $display("FAIL restart_nwrites got %0d want 1", act_data.size()); end
        else begin
            checks++; if (act_data[0] !== w || act_addr[0] !== 32'h0 || act_cyc[0] != last_c + 1) begin
                errors++; $display("FAIL restart_write got %h@%h c%0d want %h@0 c%0d",
                    act_data[0], act_addr[0], act_cyc[0], w, last_c + 1); end
        end
    endtask

    task automatic test_reset_mid();
        tick();
        i_start = 1'b1; tick(); i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ifc.i_rx_valid = 1'b1; ifc.i_rx_data = 8'($urandom_range(1, 255)); tick();
        end
        ifc.i_rx_valid = 1'b0;
        checks++; if (ifc.o_write_instruction_flag !== 1'b1) begin
            errors++; $display("FAIL midreset_pulse got %b want 1", ifc.o_write_instruction_flag); end
        i_reset = 1'b0;
        #1;
        checks++; if ({ifc.o_write_instruction_flag, o_loading, o_done, o_error} !== 4'b0 ||
                      ifc.o_instruction_to_write !== 32'h0 || ifc.o_address_to_write_inst !== 32'h0 ||
                      o_word_count !== 7'd0) begin
            errors++; $display("FAIL midreset_outputs got fl %b ld %b d %h a %h cnt %0d want all 0",
                ifc.o_write_instruction_flag, o_loading, ifc.o_instruction_to_write,
                ifc.o_address_to_write_inst, o_word_count); end
        #2;
        i_reset = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            stim = {};
            repeat ($urandom_range(1, 6)) push_word(($urandom_range(0, 3) == 0) ? HALTW : ($urandom & 32'hFFFF_FFFE));
            run_stream($urandom_range(0, 1) == 1);
            model();
            checks++; if (act_data.size() != exp_data.size()) begin
                errors++; $display("FAIL rand%0d_nwrites got %0d want %0d", it, act_data.size(), exp_data.size()); end
            else foreach (exp_data[i]) begin
                checks++; if (act_data[i] !== exp_data[i] || act_addr[i] !== exp_addr[i] || act_cyc[i] != exp_cyc[i]) begin
                    errors++; $display("FAIL rand%0d_write%0d got %h@%h c%0d want %h@%h c%0d", it, i,
                        act_data[i], act_addr[i], act_cyc[i], exp_data[i], exp_addr[i], exp_cyc[i]); end
            end
            checks++; if (o_done !== exp_done || o_error !== exp_err || o_loading !== !(exp_done || exp_err) ||
                          o_word_count !== 7'(exp_data.size())) begin
                errors++; $display("FAIL rand%0d_state got dn %b er %b ld %b cnt %0d want %b %b %b %0d", it,
                    o_done, o_error, o_loading, o_word_count, exp_done, exp_err, !(exp_done || exp_err), exp_data.size()); end
        end
    endtask

    task automatic test_timeout();
        tick();
        i_start = 1'b1; tick(); i_start = 1'b0;
        act_data = {}; act_addr = {}; act_cyc = {};
        for (int i = 0; i < 2; i++) begin
            ifc.i_rx_valid = 1'b1; ifc.i_rx_data = 8'($urandom); tick();
        end
        ifc.i_rx_valid = 1'b0;
`ifdef INSTR_LOADER_TIMEOUT_EN
        repeat (TMO - 1) tick();
        checks++; if (o_error !== 1'b0) begin
            errors++; $display("FAIL tmo_early got %b want 0", o_error); end
        tick();
        checks++; if (o_error !== 1'b1 || o_loading !== 1'b0 || act_data.size() != 0) begin
            errors++; $display("FAIL tmo_expire got er %b ld %b writes %0d want 1 0 0",
                o_error, o_loading, act_data.size()); end
        i_start = 1'b1; tick(); i_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ifc.i_rx_valid = 1'b1; ifc.i_rx_data = 8'($urandom); tick();
        end
        ifc.i_rx_valid = 1'b0;
        repeat (TMO - 2) tick();
        ifc.i_rx_valid = 1'b1; tick(); ifc.i_rx_valid = 1'b0;
        repeat (2) tick();
        checks++; if (o_error !== 1'b0 || o_loading !== 1'b1) begin
            errors++; $display("FAIL tmo_rescued got er %b ld %b want 0 1", o_error, o_loading); end
`else
        repeat (3 * TMO) tick();
        checks++; if (o_error !== 1'b0 || o_loading !== 1'b1 || act_data.size() != 0) begin
            errors++; $display("FAIL no_tmo got er %b ld %b writes %0d want 0 1 0",
                o_error, o_loading, act_data.size()); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_halt();
        test_back_to_back();
        test_overflow();
        test_restart();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
